uart_tx_frame: RTL
==================

# uart_tx_frame

Parametrised UART transmitter, successor to the fixed 8N1 `uart_tx`. Serialises one word per `start` handshake into a configurable frame:
- start bit;
- `DataBits` data bits, LSB first;
- optional even/odd parity;
- 1 or 2 stop bits.

It sits between a byte/word source (FIFO or register interface) and the TX pin. It is paced by an external oversampling strobe from `pulse_generator`.

## Interface
- `DataBits`, default 8: data bits per frame. Legal range 5..9.
- `SamplesPerBit`, default 16: `sample_trigger` pulses per bit period. Legal range 2..64.
- `ParityEnable`, default 0: 1 inserts a parity bit after the data bits.
- `ParityOdd`, default 0: selects parity sense when enabled. 0 = even (total ones incl. parity is even); 1 = odd.
- `StopBits`, default 1: number of stop bits. 1 or 2.
- `clk  input  1`: system clock. All logic is synchronous to its rising edge.
- `rst  input  1`: reset, synchronous and active-high.
- `sample_trigger  input  1`: one-`clk`-wide oversampling strobe (`SamplesPerBit` per bit).
- `data  input  DataBits`: word to send. Sampled only on the accepting edge.
- `start  input  1`: request to send `data`. Level-sensitive; ignored unless `ready`=1.
- `serial_data  output  1`: TX line. Idle/stop = 1.
- `ready  output  1`: 1 when idle and able to accept `start`.
- `done  output  1`: one-cycle pulse when a frame's last stop bit completes.

## Operation
- Frame length: N = 1 + DataBits + ParityEnable + StopBits bits. Each bit is held for exactly SamplesPerBit `sample_trigger` pulses.
- State machine IDLE -> ARMED -> START -> DATA -> (PARITY) -> STOP -> IDLE.
- **IDLE**
  - `ready`=1, `serial_data`=1.
  - On an edge with `start`=1: capture `data` into the shift register and compute parity from the captured word. Go to ARMED.
- **ARMED**
  - `ready`=0, `serial_data`=1.
  - Waits for the next edge with `sample_trigger`=1, then goes to START.
  - A trigger coincident with the accepting edge does not count.
- **START**: `serial_data`=0 for SamplesPerBit triggers.
- **DATA**: bit i (i=0..DataBits-1) is driven for SamplesPerBit triggers, LSB first.
- **PARITY**
  - Even: bit = XOR of data.
  - Odd: bit = ~XOR of data.
- **STOP**
  - `serial_data`=1 for StopBits×SamplesPerBit triggers.
  - On the edge consuming the final trigger: go to IDLE, `ready`←1, `done`←1 for one cycle.
- Counters:
  - Sample counter is $clog2(SamplesPerBit) bits, wrapping at SamplesPerBit-1.
  - Bit counter is $clog2(N) bits.
  - No counter advances on cycles without `sample_trigger`.
- `start` or `data` changes while `ready`=0 are ignored; the captured word is unaffected.
- `start` held high continuously gives back-to-back frames. A new frame is accepted on the first cycle `ready`=1. Only full-length stop bits separate frames.
- Illegal parameter values trigger an elaboration-time `$error`.

## Timing
- Reset values: `serial_data`=1, `ready`=0, `done`=0; state IDLE; counters 0.
- `ready` is held 0 for every cycle `rst`=1. It rises on the first rising edge with `rst`=0.
- `rst` mid-frame aborts immediately:
  - The line returns to 1 on the next edge.
  - No `done` is issued.
  - No partial bits appear after reset release.
- All outputs are registered; no combinational path from inputs to outputs.
- Accept latency: `ready` falls on the edge that samples `start`=1.
- Start bit latency: `serial_data` falls on the first later edge with `sample_trigger`=1 (registered, visible after that edge).
- Each bit transition occurs on the edge with the SamplesPerBit-th trigger of the previous bit.
- Frame duration: N×SamplesPerBit triggers from start-bit edge to the `ready` rise. `done` coincides with that `ready` rise.
- `start`=1 and `rst`=1 on the same edge: reset wins; the word is not accepted.

## Test plan
- **Hold in reset.** `rst`=1 for 3000 cycles with `start`=1, `data`=8'hD5 -> `serial_data`=1, `ready`=0, `done`=0 throughout.
- **8E1 (ParityEnable=1, ParityOdd=0), `data`=8'hAB.** Required line: 0, 1,1,0,1,0,1,0,1, parity 1, stop 1. Each bit 16 triggers, 176 triggers total. `ready`=0 during the frame, then one `done` pulse, then `ready`=1 and line 1 for 3000 cycles.
- **8O1, `data`=8'hAB** -> parity bit 0. All other bits identical to the 8E1 case.
- **7N2 (DataBits=7, StopBits=2), `data`=7'h55** -> 0, 1,0,1,0,1,0,1, 1,1; 160 triggers. A second `start` with 7'h7F at trigger 80 is ignored; the output matches exactly.
- **Back-to-back.** `start` held high, `data`=8'hAB then 8'hBD (8N1) -> two consecutive frames:
  - Frame 1 bits: 1,1,0,1,0,1,0,1.
  - Frame 2 bits: 1,0,1,1,1,1,0,1.
  - Exactly 16 triggers of stop between frames.
  - Two `done` pulses.
- **Reset mid-frame.** Assert `rst` at trigger 70 of an 8N1 frame -> line 1 on the next edge, no `done`. After release, `ready`=1 and a fresh 8'h00 frame transmits correctly.

Source files
------------

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - parametrised UART transmitter (start, data LSB first, optional parity, 1/2 stop)
//
// Purpose: serialises one word per accepted start request into a UART frame,
// paced by an external oversampling strobe (SamplesPerBit strobes per bit).
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   sample_trigger one-cycle oversampling strobe
//   data           word to send, captured on the accepting edge
//   start          send request, honoured only while ready=1
//   serial_data    TX line, idle/stop = 1 (registered)
//   ready          1 when idle and able to accept start (registered)
//   done           one-cycle pulse when the last stop bit completes (registered)
module uart_tx_frame #(
  parameter int DataBits      = 8,
  parameter int SamplesPerBit = 16,
  parameter int ParityEnable  = 0,
  parameter int ParityOdd     = 0,
  parameter int StopBits      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_trigger,
  input  logic [DataBits-1:0] data,
  input  logic                start,
  output logic                serial_data,
  output logic                ready,
  output logic                done
);

  localparam int NBits = 1 + DataBits + ParityEnable + StopBits;
  localparam int SW    = $clog2(SamplesPerBit);
  localparam int BW    = $clog2(NBits);

  localparam logic [SW-1:0] SampleLast = SW'(SamplesPerBit - 1);
  localparam logic [BW-1:0] DataLast   = BW'(DataBits - 1);
  localparam logic [BW-1:0] StopLast   = BW'(StopBits - 1);
  localparam logic          OddSense   = (ParityOdd != 0);

  if (DataBits < 5 || DataBits > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DataBits must be 5..9");
  end
  if (SamplesPerBit < 2 || SamplesPerBit > 64) begin : g_bad_samples
    $error("uart_tx_frame: SamplesPerBit must be 2..64");
  end
  if (ParityEnable != 0 && ParityEnable != 1) begin : g_bad_parity_en
    $error("uart_tx_frame: ParityEnable must be 0 or 1");
  end
  if (ParityOdd != 0 && ParityOdd != 1) begin : g_bad_parity_odd
    $error("uart_tx_frame: ParityOdd must be 0 or 1");
  end
  if (StopBits != 1 && StopBits != 2) begin : g_bad_stop
    $error("uart_tx_frame: StopBits must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              state;
  logic [SW-1:0]       sample_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [DataBits-1:0] shreg;
  logic                parity_bit;
  logic                bit_end;
  logic                in_frame;

  // A bit period ends on the SamplesPerBit-th strobe since the bit began.
  assign in_frame = (state == S_START) || (state == S_DATA) ||
                    (state == S_PARITY) || (state == S_STOP);
  assign bit_end  = in_frame && sample_trigger && (sample_cnt == SampleLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      serial_data <= 1'b1;
      ready       <= 1'b0;
      done        <= 1'b0;
      sample_cnt  <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      parity_bit  <= 1'b0;
    end else begin
      done <= 1'b0;

      if (in_frame && sample_trigger) begin
        sample_cnt <= (sample_cnt == SampleLast) ? '0 : sample_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          serial_data <= 1'b1;
          ready       <= 1'b1;
          // ready gates acceptance, so the first edge out of reset only raises ready.
          if (ready && start) begin
            shreg      <= data;
            parity_bit <= (^data) ^ OddSense;
            ready      <= 1'b0;
            state      <= S_ARMED;
          end
        end

        // The strobe that moves us to START is the start-bit edge itself; it is
        // not counted towards the start bit's own duration.
        S_ARMED: begin
          if (sample_trigger) begin
            state       <= S_START;
            serial_data <= 1'b0;
          end
        end

        S_START: begin
          if (bit_end) begin
            state       <= S_DATA;
            serial_data <= shreg[0];
            bit_cnt     <= '0;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            if (bit_cnt == DataLast) begin
              bit_cnt <= '0;
              if (ParityEnable != 0) begin
                state       <= S_PARITY;
                serial_data <= parity_bit;
              end else begin
                state       <= S_STOP;
                serial_data <= 1'b1;
              end
            end else begin
              bit_cnt     <= bit_cnt + 1'b1;
              shreg       <= shreg >> 1;
              serial_data <= shreg[1];
            end
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            state       <= S_STOP;
            serial_data <= 1'b1;
            bit_cnt     <= '0;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            if (bit_cnt == StopLast) begin
              state   <= S_IDLE;
              ready   <= 1'b1;
              done    <= 1'b1;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        default: begin
          state       <= S_IDLE;
          serial_data <= 1'b1;
        end
      endcase
    end
  end

endmodule
